bmp_pixel_packer: RTL

BMP_PIXEL_PACKER -- requirements
Module: bmp_pixel_packer

---
 rtl/bmp_pixel_packer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bmp_pixel_packer.sv
// Purpose: packs a stream of 24-bit BGR pixels into 32-bit little-endian byte words
//          (4 pixels -> 3 words), tagging the last word of each frame.
// Latency: a word appears on out_word the cycle after the pixel that completes it.
// Backpressure: in_ready drops only when a word is pending, downstream stalls and the
//               next pixel would produce another word; a PH0 pixel is always taken.
// Ports:
//   clk, rst                     - rising-edge clock, synchronous active-high reset
//   input_pixel/input_is_valid   - pixel stream in ([7:0]=B first byte, [23:16]=R)
//   in_ready                     - pixel accepted this cycle when input_is_valid=1
//   out_word/out_valid/out_ready - packed word stream out (byte n at [8n+7:8n])
//   out_last                     - marks the final word of a frame
//   frame_done                   - one-cycle pulse after the out_last word is taken
module bmp_pixel_packer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] input_pixel,
  input  logic        input_is_valid,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done
);

  localparam int FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  // Phase = number of pixels of the current 4-pixel group already consumed.
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e             phase_q, phase_d;
  logic [23:0]        resid_q, resid_d;     // leftover bytes, oldest at [7:0]
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [31:0]        word_q, word_d;
  logic               vld_q, vld_d;
  logic               last_q, last_d;
  logic               fdone_q, fdone_d;

  logic               pix_hs;
  logic               word_hs;
  logic               frame_end;

  // A PH0 pixel never produces a word, so it can be taken even while stalled.
  assign in_ready  = rst | (phase_q == PH0) | ~vld_q | out_ready;
  assign pix_hs    = input_is_valid & in_ready;
  assign word_hs   = vld_q & out_ready;
  assign frame_end = (pix_cnt_q == CNT_W'(FRAME_PIX - 1));

  assign out_word   = word_q;
  assign out_valid  = vld_q;
  assign out_last   = last_q;
  assign frame_done = fdone_q;

  always_comb begin
    phase_d   = phase_q;
    resid_d   = resid_q;
    pix_cnt_d = pix_cnt_q;
    word_d    = word_q;
    vld_d     = vld_q;
    last_d    = last_q;
    fdone_d   = word_hs & last_q;

    // Word consumed: drop valid but keep the data bits; a same-edge
    // pixel accept below overrides this so there is no bubble.
    if (word_hs) begin
      vld_d  = 1'b0;
      last_d = 1'b0;
    end

    if (pix_hs) begin
      pix_cnt_d = frame_end ? '0 : pix_cnt_q + CNT_W'(1);
      case (phase_q)
        PH0: begin
          resid_d = input_pixel;
          phase_d = PH1;
        end
        PH1: begin
          word_d  = {input_pixel[7:0], resid_q};
          resid_d = {8'h00, input_pixel[23:8]};
          vld_d   = 1'b1;
          last_d  = frame_end;
          phase_d = PH2;
        end
        PH2: begin
          word_d  = {input_pixel[15:0], resid_q[15:0]};
          resid_d = {16'h0000, input_pixel[23:16]};
          vld_d   = 1'b1;
          last_d  = frame_end;
          phase_d = PH3;
        end
        default: begin
          word_d  = {input_pixel, resid_q[7:0]};
          resid_d = '0;
          vld_d   = 1'b1;
          last_d  = frame_end;
          phase_d = PH0;
        end
      endcase
      // Frame size is a multiple of 4, so this only restates the PH3 wrap;
      // it keeps every frame starting cleanly at PH0 regardless.
      if (frame_end) begin
        phase_d = PH0;
        resid_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH0;
      resid_q   <= '0;
      pix_cnt_q <= '0;
      word_q    <= '0;
      vld_q     <= 1'b0;
      last_q    <= 1'b0;
      fdone_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      resid_q   <= resid_d;
      pix_cnt_q <= pix_cnt_d;
      word_q    <= word_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      fdone_q   <= fdone_d;
    end
  end

endmodule
